// File: rtl/vliw_regfile.sv
// vliw_regfile: NR-read / NW-write register file with a per-register busy scoreboard. Optional macro: REGFILE_BYPASS_EN.
// Latency: state updates on negedge clk; reads are combinational; wr_collision is registered for one edge.
// Backpressure: none. Every enabled write/reserve strobe is consumed on each edge.
module vliw_regfile #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NR       = 4,
    parameter int NW       = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NW-1:0]       wr_en,
    input  logic [NW*AW-1:0]    wr_addr,
    input  logic [NW*WIDTH-1:0] wr_data,
    input  logic [NW-1:0]       rsv_en,
    input  logic [NW*AW-1:0]    rsv_addr,
    input  logic [NR*AW-1:0]    rd_addr,
    output logic [NR*WIDTH-1:0] rd_data,
    output logic [NR-1:0]       rd_busy,
    output logic                wr_collision
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             coll_q;
    logic             coll_d;
`ifdef REGFILE_BYPASS_EN
    logic             byp_hit;
`endif

    // Ascending port order lets the highest-indexed writer win; reserves run last so they beat writes.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int p = 0; p < NW; p++) begin
            if (wr_en[p]) begin
                mem_d[wr_addr[p*AW +: AW]]  = wr_data[p*WIDTH +: WIDTH];
                busy_d[wr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        for (int p = 0; p < NW; p++) begin
            if (rsv_en[p]) begin
                busy_d[rsv_addr[p*AW +: AW]] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            mem_d[0]  = '0;
            busy_d[0] = 1'b0;
        end
    end

    always_comb begin
        coll_d = 1'b0;
        for (int p = 0; p < NW; p++) begin
            for (int q = p + 1; q < NW; q++) begin
                if (wr_en[p] && wr_en[q] &&
                    (wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW]) &&
                    !((ZERO_REG != 0) && (wr_addr[p*AW +: AW] == '0))) begin
                    coll_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
`ifdef REGFILE_BYPASS_EN
        byp_hit = 1'b0;
`endif
        for (int i = 0; i < NR; i++) begin
            rd_data[i*WIDTH +: WIDTH] = mem_q[rd_addr[i*AW +: AW]];
            rd_busy[i]                = busy_q[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            // Forwarded reads report the busy state the register will have after this edge.
            byp_hit = 1'b0;
            for (int p = 0; p < NW; p++) begin
                if (wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr[i*AW +: AW])) begin
                    rd_data[i*WIDTH +: WIDTH] = wr_data[p*WIDTH +: WIDTH];
                    rd_busy[i]                = 1'b0;
                    byp_hit                   = 1'b1;
                end
            end
            if (byp_hit) begin
                for (int p = 0; p < NW; p++) begin
                    if (rsv_en[p] && (rsv_addr[p*AW +: AW] == rd_addr[i*AW +: AW])) begin
                        rd_busy[i] = 1'b1;
                    end
                end
            end
`endif
            if ((ZERO_REG != 0) && (rd_addr[i*AW +: AW] == '0)) begin
                rd_data[i*WIDTH +: WIDTH] = '0;
                rd_busy[i]                = 1'b0;
            end
        end
    end

    // Datapath registers update on the falling edge; reset discards same-cycle writes and reserves.
    always_ff @(negedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
            coll_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            coll_q <= coll_d;
        end
    end

    assign wr_collision = coll_q;

endmodule

// File: tb/tb_vliw_regfile.sv
// Randomized + directed bench for vliw_regfile with a queue-based scoreboard and a spec-level reference model.
module tb_vliw_regfile;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NR = 4;
    localparam int NW = 2;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [NW-1:0]     wr_en, rsv_en;
    logic [NW*AW-1:0]  wr_addr, rsv_addr;
    logic [NW*W-1:0]   wr_data;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*W-1:0]   rd_data;
    logic [NR-1:0]     rd_busy;
    logic              wr_collision;

    // Second instance for the small-geometry sweep.
    logic [2:0]        wr_en2, rsv_en2;
    logic [8:0]        wr_addr2, rsv_addr2;
    logic [47:0]       wr_data2;
    logic [5:0]        rd_addr2;
    logic [31:0]       rd_data2;
    logic [1:0]        rd_busy2;
    logic              wr_collision2;

    vliw_regfile #(.WIDTH(W), .DEPTH(D), .NR(NR), .NW(NW), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_collision(wr_collision)
    );

    vliw_regfile #(.WIDTH(16), .DEPTH(8), .NR(2), .NW(3), .ZERO_REG(0)) dut2 (
        .clk(clk), .reset(reset),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .rsv_en(rsv_en2), .rsv_addr(rsv_addr2),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
        .wr_collision(wr_collision2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR*W-1:0] d;
        logic [NR-1:0]   b;
        logic            c;
        int              cyc;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  b;
        int          cyc;
    } exp2_t;

    exp_t  q[$];
    exp2_t q2[$];

    logic [W-1:0] m_mem [D];
    logic         m_busy [D];
    logic         m_coll;
    logic [15:0]  sv [8];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input int c, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, c, act, exp);
        end
    endtask

    // Monitor: compare outputs just before the active (falling) edge.
    initial begin
        exp_t  e;
        exp2_t e2;
        forever begin
            @(posedge clk);
            #4;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_data", e.cyc, 128'(rd_data), 128'(e.d));
                chk("rd_busy", e.cyc, 128'(rd_busy), 128'(e.b));
                chk("wr_collision", e.cyc, 128'(wr_collision), 128'(e.c));
            end
            if (q2.size() > 0) begin
                e2 = q2.pop_front();
                chk("sweep_rd_data", e2.cyc, 128'(rd_data2), 128'(e2.d));
                chk("sweep_rd_busy", e2.cyc, 128'(rd_busy2), 128'(e2.b));
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
        cyc++;
        reset    = 1'b0;
        wr_en    = '0;
        rsv_en   = '0;
        wr_addr  = '0;
        rsv_addr = '0;
        wr_data  = '0;
        rd_addr  = '0;
        wr_en2   = '0;
        rsv_en2  = '0;
        wr_addr2 = '0;
        rsv_addr2 = '0;
        wr_data2 = '0;
        rd_addr2 = '0;
    endtask

    task automatic wr(input int p, input int a, input logic [W-1:0] d);
        wr_en[p]             = 1'b1;
        wr_addr[p*AW +: AW]  = AW'(a);
        wr_data[p*W +: W]    = d;
    endtask

    task automatic rsv(input int p, input int a);
        rsv_en[p]            = 1'b1;
        rsv_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic rd(input int i, input int a);
        rd_addr[i*AW +: AW]  = AW'(a);
    endtask

    // Reference model: predict this cycle's reads, then apply the edge.
    task automatic commit(input bit do_chk);
        exp_t        e;
        int          a;
        logic [W-1:0] nd [D];
        bit          whit [D];
        bit          rhit [D];
        bit          nc;
        if (do_chk) begin
            e.cyc = cyc;
            e.c   = m_coll;
            for (int i = 0; i < NR; i++) begin
                a = int'(rd_addr[i*AW +: AW]);
                e.d[i*W +: W] = m_mem[a];
                e.b[i]        = m_busy[a];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < NW; p++) begin
                    if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) begin
                        e.d[i*W +: W] = wr_data[p*W +: W];
                        e.b[i]        = 1'b0;
                        for (int s = 0; s < NW; s++)
                            if (rsv_en[s] && int'(rsv_addr[s*AW +: AW]) == a) e.b[i] = 1'b1;
                    end
                end
`endif
                if (a == 0) begin
                    e.d[i*W +: W] = '0;
                    e.b[i]        = 1'b0;
                end
            end
            q.push_back(e);
        end
        nc = 1'b0;
        for (int p = 0; p < NW; p++)
            for (int s = p + 1; s < NW; s++)
                if (wr_en[p] && wr_en[s] && wr_addr[p*AW +: AW] == wr_addr[s*AW +: AW] &&
                    int'(wr_addr[p*AW +: AW]) != 0) nc = 1'b1;
        for (int r = 0; r < D; r++) begin
            nd[r]   = m_mem[r];
            whit[r] = 1'b0;
            rhit[r] = 1'b0;
        end
        for (int p = 0; p < NW; p++) begin
            if (wr_en[p]) begin
                a = int'(wr_addr[p*AW +: AW]);
                nd[a]   = wr_data[p*W +: W];
                whit[a] = 1'b1;
            end
            if (rsv_en[p]) rhit[int'(rsv_addr[p*AW +: AW])] = 1'b1;
        end
        for (int r = 0; r < D; r++) begin
            if (reset || r == 0) begin
                m_mem[r]  = '0;
                m_busy[r] = 1'b0;
            end else begin
                m_mem[r] = nd[r];
                if (rhit[r])      m_busy[r] = 1'b1;
                else if (whit[r]) m_busy[r] = 1'b0;
            end
        end
        m_coll = reset ? 1'b0 : nc;
    endtask

    initial begin
        for (int r = 0; r < D; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
        m_coll = 1'b0;

        // Initial reset: DUT state unknown beforehand, so nothing to check yet.
        next(); reset = 1'b1; commit(1'b0);

        // Reset discards a same-cycle write and clears earlier data.
        next(); wr(0, 5, 32'hDEADBEEF); rd(0, 5); commit(1'b1);
        next(); rd(0, 5); rd(1, 6); reset = 1'b1; wr(0, 6, 32'h1234); commit(1'b1);
        next(); rd(0, 5); rd(1, 6); rd(2, 7); rd(3, 3); commit(1'b1);

        // Priority and collision pulse.
        next(); wr(0, 7, 32'h11111111); wr(1, 7, 32'h22222222); rd(1, 7); commit(1'b1);
        next(); rd(1, 7); commit(1'b1);
        next(); rd(1, 7); commit(1'b1);

        // Scoreboard: reserve beats a same-cycle write; a lone write clears busy.
        next(); rsv(0, 3); rd(0, 3); commit(1'b1);
        next(); rd(0, 3); wr(1, 3, 32'hA5); rsv(0, 3); commit(1'b1);
        next(); rd(0, 3); wr(0, 3, 32'h5A); commit(1'b1);
        next(); rd(0, 3); commit(1'b1);

        // Zero register.
        next(); wr(0, 0, 32'hFFFFFFFF); wr(1, 0, 32'hFFFFFFFF); rsv(0, 0); rsv(1, 0); rd(0, 0); commit(1'b1);
        next(); rd(0, 0); rd(1, 0); commit(1'b1);

        // Bypass probe on read port 2.
        next(); wr(0, 9, 32'hCAFEF00D); rd(2, 9); commit(1'b1);
        next(); rd(2, 9); commit(1'b1);

        // Randomized traffic with narrow addresses to provoke conflicts.
        for (int k = 0; k < 600; k++) begin
            next();
            for (int p = 0; p < NW; p++) begin
                if ($urandom_range(0, 1) == 1)
                    wr(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, D-1) : $urandom_range(0, 7), $urandom);
                if ($urandom_range(0, 3) == 0)
                    rsv(p, $urandom_range(0, 7));
            end
            for (int i = 0; i < NR; i++) rd(i, $urandom_range(0, 9));
            if ($urandom_range(0, 63) == 0) reset = 1'b1;
            commit(1'b1);
        end

        // Small-geometry sweep: 8 registers written over 3 cycles, then read back.
        for (int r = 0; r < 8; r++) sv[r] = {4'(r), 12'($urandom)};
        for (int k = 0; k < 3; k++) begin
            next();
            for (int p = 0; p < 3; p++) begin
                if (k*3 + p < 8) begin
                    wr_en2[p]          = 1'b1;
                    wr_addr2[p*3 +: 3] = 3'(k*3 + p);
                    wr_data2[p*16 +: 16] = sv[k*3 + p];
                end
            end
            commit(1'b1);
        end
        for (int j = 0; j < 4; j++) begin
            exp2_t e2;
            next();
            rd_addr2 = {3'(2*j + 1), 3'(2*j)};
            e2.d   = {sv[2*j + 1], sv[2*j]};
            e2.b   = 2'b00;
            e2.cyc = cyc;
            q2.push_back(e2);
            commit(1'b1);
        end

        next(); commit(1'b0);
        next(); commit(1'b0);
        chk("scoreboard_drained", cyc, 128'(q.size() + q2.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vliw_regfile.md
# vliw_regfile

Parametrised multi-port register file for the VLIW datapath, replacing per-slot 32-bit registers built from individual `D_ff` cells. It provides NR combinational read ports and NW write ports, one write port per issue slot. Same-address write conflicts are resolved by fixed priority. A per-register busy scoreboard lets the issue stage detect pending producers. The block sits between decode/issue (read and reserve) and writeback (write).

## Interface
- `WIDTH`, default 32, data bits per register.
- `DEPTH`, default 32, number of registers; must be a power of two, at least 2. `AW = $clog2(DEPTH)` is a derived localparam.
- `NR`, default 4, number of read ports.
- `NW`, default 2, number of write ports; also the number of reserve ports.
- `ZERO_REG`, default 1. When 1, register 0 always reads 0, ignores writes and is never busy.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `wr_en` in NW: per-port write strobe.
- `wr_addr` in NW*AW: port p at bits [p*AW +: AW].
- `wr_data` in NW*WIDTH: port p at bits [p*WIDTH +: WIDTH].
- `rsv_en` in NW: per-port reserve strobe (sets busy).
- `rsv_addr` in NW*AW: packed as `wr_addr`.
- `rd_addr` in NR*AW: read addresses.
- `rd_data` out NR*WIDTH: read data.
- `rd_busy` out NR: busy bit of the addressed register.
- `wr_collision` out 1: registered; pulses for one cycle when two or more enabled write ports targeted the same register.

## Operation
- Storage: DEPTH x WIDTH array plus a DEPTH-bit busy vector.
- Write: for each register r, the highest-indexed port p with `wr_en[p]` and `wr_addr[p]==r` supplies the data. Lower ports targeting r are dropped.
- Busy update, evaluated per register:
  - A reserve hit on r sets busy.
  - Otherwise, any write hit on r clears busy.
  - Reserve beats write when both hit r in the same cycle, because the new producer supersedes the old one.
- Writes to a non-busy register are legal and do not alter busy.
- Read: `rd_data`/`rd_busy` are combinational from stored state (see Configuration for bypass). Address 0 with ZERO_REG=1 returns 0 and not busy.
- `wr_collision`: set for the cycle after any pair p<q with both enabled and equal `wr_addr`, excluding address 0 when ZERO_REG=1; low otherwise.
- Reset, when high at the active edge:
  - The data array is cleared to 0.
  - The busy vector is cleared.
  - `wr_collision` goes to 0.
  - Any writes or reserves presented in the same cycle are discarded.
  - Reset asserted mid-operation loses all pending reservations.
- After reset, all `rd_data`=0, all `rd_busy`=0 and `wr_collision`=0.

## Timing
- All state updates happen on negedge `clk`, matching the datapath register convention. Reset is sampled on that same edge.
- Write latency: data presented before negedge N is visible on `rd_data` immediately after negedge N without bypass, or combinationally before it with bypass.
- Busy set/clear takes effect after the same edge.
- `wr_collision` is valid after the edge that processed the conflicting writes and holds until the next edge.
- No handshake; every enabled strobe is consumed on each edge.
- Out-of-range addresses cannot occur because DEPTH = 2^AW.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read port whose address matches an enabled write port in the current cycle returns that port's `wr_data`, using the highest-indexed matching port.
  - `rd_busy` for that port is the post-edge busy value: 0 unless a reserve also hits.
  - Address 0 with ZERO_REG=1 is never bypassed.
- Undefined: reads return stored state only, and a same-cycle write is seen one edge later.

## Test plan
- Reset: write 0xDEADBEEF to r5, then assert `reset` for one edge while `wr_en[0]`=1 to r6 with 0x1234. Required: r5 and r6 read 0, all busy 0, `wr_collision`=0.
- Priority: port0 writes 0x11111111 and port1 writes 0x22222222, both to r7. Required: after the edge r7=0x22222222 and `wr_collision`=1 for one cycle, then 0.
- Scoreboard: reserve r3 via port0, so `rd_busy` is 1. Next cycle, port1 writes 0xA5 to r3 while port0 reserves r3. Required: r3=0xA5 and busy remains 1. A following write alone clears busy.
- Zero register: ZERO_REG=1, write 0xFFFFFFFF to r0 and reserve r0 on both ports. Required: r0 reads 0, not busy, `wr_collision`=0.
- Bypass: write 0xCAFEF00D to r9 while `rd_addr[2]`=9. Required: same-cycle `rd_data[2]`=0xCAFEF00D with `REGFILE_BYPASS_EN`, and the old value 0 without it.
- Parameter sweep: WIDTH=16, DEPTH=8, NR=2, NW=3. Write distinct values to all 8 registers over 3 cycles. Required: every read returns its last written value.
